lfst_dep: RTL and testbench

Last-fetched-store table (LFST) for store-set memory dependence prediction in the rename stage. It consumes the per-slot store-set IDs and the intra-bundle select codes from the store-set dependency checker, and returns a one-cycle-registered producer-store tag for every instruction that belongs to a store set. It records each renamed store as the newest member of its set, and retires table entries when the recorded store issues. The table is invalidated on pipeline flush.

---
 rtl/lfst_dep.sv | 155 +++++++++++++++
 tb/tb_lfst_dep.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfst_dep.sv
// Last-fetched-store table: one-cycle registered producer-store lookup per rename slot.
// Records renamed stores per store set; store issue retires the entry. No backpressure.
module lfst_dep #(
    parameter int SSID_W = 7,
    parameter int TAG_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ren_vld_i,
    input  logic [SSID_W-1:0] ssid0_i,
    input  logic [SSID_W-1:0] ssid1_i,
    input  logic [SSID_W-1:0] ssid2_i,
    input  logic [SSID_W-1:0] ssid3_i,
    input  logic              ssid0_vld_i,
    input  logic              ssid1_vld_i,
    input  logic              ssid2_vld_i,
    input  logic              ssid3_vld_i,
    input  logic              type0_i,
    input  logic              type1_i,
    input  logic              type2_i,
    input  logic              type3_i,
    input  logic [TAG_W-1:0]  stag0_i,
    input  logic [TAG_W-1:0]  stag1_i,
    input  logic [TAG_W-1:0]  stag2_i,
    input  logic [TAG_W-1:0]  stag3_i,
    input  logic              ssid1sel_i,
    input  logic [1:0]        ssid2sel_i,
    input  logic [1:0]        ssid3sel_i,
    input  logic              st_iss_vld_i,
    input  logic [SSID_W-1:0] st_iss_ssid_i,
    input  logic [TAG_W-1:0]  st_iss_tag_i,
    input  logic              flush_i,
    output logic              dep_vld_o,
    output logic              dep0_vld_o,
    output logic              dep1_vld_o,
    output logic              dep2_vld_o,
    output logic              dep3_vld_o,
    output logic [TAG_W-1:0]  dep0_tag_o,
    output logic [TAG_W-1:0]  dep1_tag_o,
    output logic [TAG_W-1:0]  dep2_tag_o,
    output logic [TAG_W-1:0]  dep3_tag_o
);
    localparam int DEPTH = 1 << SSID_W;

    logic [SSID_W-1:0] ssid [4];
    logic [TAG_W-1:0]  stag [4];
    logic [3:0]        ssid_vld;
    logic [3:0]        is_st;

    assign ssid     = '{ssid0_i, ssid1_i, ssid2_i, ssid3_i};
    assign stag     = '{stag0_i, stag1_i, stag2_i, stag3_i};
    assign ssid_vld = {ssid3_vld_i, ssid2_vld_i, ssid1_vld_i, ssid0_vld_i};
    assign is_st    = {type3_i, type2_i, type1_i, type0_i};

    logic [DEPTH-1:0] tbl_vld_q, tbl_vld_d;
    logic [TAG_W-1:0] tbl_tag_q [DEPTH];

    logic [3:0]       wr;
    logic [3:0]       from_tbl;
    logic [1:0]       src [4];
    logic [3:0]       look_v;
    logic [TAG_W-1:0] look_t [4];

    logic             dep_vld_q;
    logic [3:0]       dep_v_q;
    logic [TAG_W-1:0] dep_t_q [4];

    // Decode the checker's select codes into "use table" or "forward from slot k".
    always_comb begin
        from_tbl = {&ssid3sel_i, ssid2sel_i[1], ssid1sel_i, 1'b1};
        src[0]   = 2'd0;
        src[1]   = 2'd0;
        src[2]   = {1'b0, ssid2sel_i[0]};
        src[3]   = ssid3sel_i;
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            wr[n]     = ren_vld_i & ssid_vld[n] & is_st[n];
            look_v[n] = 1'b0;
            look_t[n] = stag[src[n]];
            if (from_tbl[n]) begin
                // A store issuing this cycle that still owns the entry hides it from lookup.
                look_v[n] = tbl_vld_q[ssid[n]] &
                            ~(st_iss_vld_i && (st_iss_ssid_i == ssid[n]) &&
                              (tbl_tag_q[ssid[n]] == st_iss_tag_i));
                look_t[n] = tbl_tag_q[ssid[n]];
            end else begin
                look_v[n] = 1'b1;
            end
            look_v[n] = look_v[n] & ssid_vld[n];
        end
    end

    // Invalidate first, then rename writes in slot order so the youngest store wins.
    always_comb begin
        tbl_vld_d = tbl_vld_q;
        if (st_iss_vld_i && tbl_vld_q[st_iss_ssid_i] &&
            (tbl_tag_q[st_iss_ssid_i] == st_iss_tag_i)) begin
            tbl_vld_d[st_iss_ssid_i] = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
            if (wr[n]) begin
                tbl_vld_d[ssid[n]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            tbl_vld_q <= '0;
        end else begin
            tbl_vld_q <= tbl_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && !flush_i) begin
            for (int n = 0; n < 4; n++) begin
                if (wr[n]) begin
                    tbl_tag_q[ssid[n]] <= stag[n];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dep_vld_q <= 1'b0;
            dep_v_q   <= '0;
            for (int n = 0; n < 4; n++) begin
                dep_t_q[n] <= '0;
            end
        end else begin
            dep_vld_q <= ren_vld_i & ~flush_i;
            dep_v_q   <= look_v & {4{ren_vld_i & ~flush_i}};
            if (ren_vld_i && !flush_i) begin
                for (int n = 0; n < 4; n++) begin
                    dep_t_q[n] <= look_t[n];
                end
            end
        end
    end

    assign dep_vld_o  = dep_vld_q;
    assign dep0_vld_o = dep_v_q[0];
    assign dep1_vld_o = dep_v_q[1];
    assign dep2_vld_o = dep_v_q[2];
    assign dep3_vld_o = dep_v_q[3];
    assign dep0_tag_o = dep_t_q[0];
    assign dep1_tag_o = dep_t_q[1];
    assign dep2_tag_o = dep_t_q[2];
    assign dep3_tag_o = dep_t_q[3];

endmodule

// File: tb/tb_lfst_dep.sv
// Scenario bench for lfst_dep: expected outputs queued per bundle and compared one cycle later.
module tb_lfst_dep;
    logic       clk_i;
    logic       rst_n_i;
    logic       ren_vld_i;
    logic [6:0] ssid [4];
    logic [3:0] ssid_vld;
    logic [3:0] typ;
    logic [5:0] stag [4];
    logic       ssid1sel_i;
    logic [1:0] ssid2sel_i;
    logic [1:0] ssid3sel_i;
    logic       st_iss_vld_i;
    logic [6:0] st_iss_ssid_i;
    logic [5:0] st_iss_tag_i;
    logic       flush_i;
    logic       dep_vld_o;
    logic       dep0_vld_o, dep1_vld_o, dep2_vld_o, dep3_vld_o;
    logic [5:0] dep0_tag_o, dep1_tag_o, dep2_tag_o, dep3_tag_o;

    lfst_dep #(.SSID_W(7), .TAG_W(6)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ren_vld_i(ren_vld_i),
        .ssid0_i(ssid[0]), .ssid1_i(ssid[1]), .ssid2_i(ssid[2]), .ssid3_i(ssid[3]),
        .ssid0_vld_i(ssid_vld[0]), .ssid1_vld_i(ssid_vld[1]),
        .ssid2_vld_i(ssid_vld[2]), .ssid3_vld_i(ssid_vld[3]),
        .type0_i(typ[0]), .type1_i(typ[1]), .type2_i(typ[2]), .type3_i(typ[3]),
        .stag0_i(stag[0]), .stag1_i(stag[1]), .stag2_i(stag[2]), .stag3_i(stag[3]),
        .ssid1sel_i(ssid1sel_i), .ssid2sel_i(ssid2sel_i), .ssid3sel_i(ssid3sel_i),
        .st_iss_vld_i(st_iss_vld_i), .st_iss_ssid_i(st_iss_ssid_i),
        .st_iss_tag_i(st_iss_tag_i), .flush_i(flush_i),
        .dep_vld_o(dep_vld_o),
        .dep0_vld_o(dep0_vld_o), .dep1_vld_o(dep1_vld_o),
        .dep2_vld_o(dep2_vld_o), .dep3_vld_o(dep3_vld_o),
        .dep0_tag_o(dep0_tag_o), .dep1_tag_o(dep1_tag_o),
        .dep2_tag_o(dep2_tag_o), .dep3_tag_o(dep3_tag_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        dv;
        logic [3:0]  v;
        logic [23:0] t;
        logic [23:0] tm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic dv, input logic [3:0] v, input logic [3:0] cm,
                                input logic [5:0] t0, input logic [5:0] t1,
                                input logic [5:0] t2, input logic [5:0] t3);
        exp_t r;
        r.dv = dv;
        r.v  = v;
        r.t  = {t3, t2, t1, t0};
        r.tm = {{6{cm[3]}}, {6{cm[2]}}, {6{cm[1]}}, {6{cm[0]}}};
        return r;
    endfunction

    function automatic logic [4:0] obs_v();
        return {dep_vld_o, dep3_vld_o, dep2_vld_o, dep1_vld_o, dep0_vld_o};
    endfunction

    function automatic logic [23:0] obs_t();
        return {dep3_tag_o, dep2_tag_o, dep1_tag_o, dep0_tag_o};
    endfunction

    task automatic idle();
        rst_n_i = 1'b1; ren_vld_i = 1'b0; flush_i = 1'b0;
        ssid_vld = '0; typ = '0;
        for (int n = 0; n < 4; n++) begin ssid[n] = '0; stag[n] = '0; end
        ssid1sel_i = 1'b1; ssid2sel_i = 2'b10; ssid3sel_i = 2'b11;
        st_iss_vld_i = 1'b0; st_iss_ssid_i = '0; st_iss_tag_i = '0;
    endtask

    task automatic slot(input int n, input logic [6:0] id, input logic st, input logic [5:0] tg);
        ren_vld_i = 1'b1; ssid_vld[n] = 1'b1; ssid[n] = id; typ[n] = st; stag[n] = tg;
    endtask

    task automatic issue(input logic [6:0] id, input logic [5:0] tg);
        st_iss_vld_i = 1'b1; st_iss_ssid_i = id; st_iss_tag_i = tg;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            idle();
            for (int n = 0; n < 4; n++) slot(n, 7'd5, 1'b0, 6'd0);
            if (s == 0) begin rst_n_i = 1'b0; sb.push_back(mk(0, 4'h0, 4'hf, 0, 0, 0, 0)); end
            else sb.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 0));
            tick();
            e = sb.pop_front();
            total++;
            if (obs_v() !== {e.dv, e.v}) begin bad++; $display("FAIL reset[%0d] vld got %b want %b", s, obs_v(), {e.dv, e.v}); end
            total++;
            if ((obs_t() & e.tm) !== (e.t & e.tm)) begin bad++; $display("FAIL reset[%0d] tag got %h want %h", s, obs_t() & e.tm, e.t & e.tm); end
        end
    endtask

    task automatic test_intra_bundle();
        for (int s = 0; s < 4; s++) begin
            idle();
            case (s)
                0: begin
                    slot(0, 7'd9, 1'b1, 6'd3); slot(2, 7'd9, 1'b0, 6'd0); ssid2sel_i = 2'b00;
                    slot(3, 7'd9, 1'b1, 6'd7); ssid3sel_i = 2'b00;
                    sb.push_back(mk(1, 4'b1100, 4'b1100, 0, 0, 3, 3));
                end
                1: begin slot(0, 7'd9, 1'b0, 6'd0); sb.push_back(mk(1, 4'b0001, 4'b0001, 7, 0, 0, 0)); end
                2: begin
                    slot(1, 7'd10, 1'b1, 6'd1); slot(2, 7'd10, 1'b1, 6'd2);
                    slot(3, 7'd10, 1'b0, 6'd0); ssid3sel_i = 2'b10;
                    sb.push_back(mk(1, 4'b1000, 4'b1000, 0, 0, 0, 2));
                end
                default: begin slot(0, 7'd10, 1'b0, 6'd0); sb.push_back(mk(1, 4'b0001, 4'b0001, 2, 0, 0, 0)); end
            endcase
            tick();
            e = sb.pop_front();
            total++;
            if (obs_v() !== {e.dv, e.v}) begin bad++; $display("FAIL intra[%0d] vld got %b want %b", s, obs_v(), {e.dv, e.v}); end
            total++;
            if ((obs_t() & e.tm) !== (e.t & e.tm)) begin bad++; $display("FAIL intra[%0d] tag got %h want %h", s, obs_t() & e.tm, e.t & e.tm); end
        end
    endtask

    task automatic test_issue_bypass();
        for (int s = 0; s < 7; s++) begin
            idle();
            case (s)
                0: begin slot(0, 7'd12, 1'b1, 6'd4); sb.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0)); end
                1: begin slot(0, 7'd12, 1'b0, 6'd0); issue(7'd12, 6'd4); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
                2: begin slot(0, 7'd12, 1'b0, 6'd0); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
                3: begin slot(0, 7'd12, 1'b1, 6'd4); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
                4: begin slot(0, 7'd12, 1'b0, 6'd0); issue(7'd12, 6'd5); sb.push_back(mk(1, 1, 1, 4, 0, 0, 0)); end
                5: begin issue(7'd12, 6'd4); sb.push_back(mk(0, 0, 1, 4, 0, 0, 0)); end
                default: begin slot(0, 7'd12, 1'b0, 6'd0); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
            endcase
            tick();
            e = sb.pop_front();
            total++;
            if (obs_v() !== {e.dv, e.v}) begin bad++; $display("FAIL bypass[%0d] vld got %b want %b", s, obs_v(), {e.dv, e.v}); end
            total++;
            if ((obs_t() & e.tm) !== (e.t & e.tm)) begin bad++; $display("FAIL bypass[%0d] tag got %h want %h", s, obs_t() & e.tm, e.t & e.tm); end
        end
    endtask

    task automatic test_write_over_issue();
        for (int s = 0; s < 4; s++) begin
            idle();
            case (s)
                0: begin slot(0, 7'd12, 1'b1, 6'd4); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
                1: begin slot(0, 7'd12, 1'b1, 6'd8); issue(7'd12, 6'd4); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
                2: begin slot(0, 7'd12, 1'b0, 6'd0); issue(7'd12, 6'd4); sb.push_back(mk(1, 1, 1, 8, 0, 0, 0)); end
                default: begin slot(0, 7'd12, 1'b0, 6'd0); sb.push_back(mk(1, 1, 1, 8, 0, 0, 0)); end
            endcase
            tick();
            e = sb.pop_front();
            total++;
            if (obs_v() !== {e.dv, e.v}) begin bad++; $display("FAIL wrprio[%0d] vld got %b want %b", s, obs_v(), {e.dv, e.v}); end
            total++;
            if ((obs_t() & e.tm) !== (e.t & e.tm)) begin bad++; $display("FAIL wrprio[%0d] tag got %h want %h", s, obs_t() & e.tm, e.t & e.tm); end
        end
    endtask

    task automatic test_flush();
        for (int s = 0; s < 4; s++) begin
            idle();
            for (int n = 0; n < 3; n++) slot(n, 7'(n + 1), s == 0, 6'(n + 11));
            case (s)
                0: sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                1: sb.push_back(mk(1, 4'b0111, 4'b0111, 11, 12, 13, 0));
                2: begin slot(3, 7'd4, 1'b1, 6'd14); flush_i = 1'b1; sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
                default: begin slot(3, 7'd4, 1'b0, 6'd0); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
            endcase
            tick();
            e = sb.pop_front();
            total++;
            if (obs_v() !== {e.dv, e.v}) begin bad++; $display("FAIL flush[%0d] vld got %b want %b", s, obs_v(), {e.dv, e.v}); end
            total++;
            if ((obs_t() & e.tm) !== (e.t & e.tm)) begin bad++; $display("FAIL flush[%0d] tag got %h want %h", s, obs_t() & e.tm, e.t & e.tm); end
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            idle();
            case (s)
                0: begin slot(0, 7'd20, 1'b1, 6'd21); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
                1: begin
                    slot(0, 7'd20, 1'b0, 6'd0); slot(1, 7'd20, 1'b1, 6'd22);
                    sb.push_back(mk(1, 4'b0011, 4'b0011, 21, 21, 0, 0));
                end
                default: begin slot(0, 7'd20, 1'b0, 6'd0); sb.push_back(mk(1, 1, 1, 22, 0, 0, 0)); end
            endcase
            tick();
            e = sb.pop_front();
            total++;
            if (obs_v() !== {e.dv, e.v}) begin bad++; $display("FAIL b2b[%0d] vld got %b want %b", s, obs_v(), {e.dv, e.v}); end
            total++;
            if ((obs_t() & e.tm) !== (e.t & e.tm)) begin bad++; $display("FAIL b2b[%0d] tag got %h want %h", s, obs_t() & e.tm, e.t & e.tm); end
        end
    endtask

    task automatic test_mid_reset();
        for (int s = 0; s < 4; s++) begin
            idle();
            slot(0, 7'd30, s == 0, 6'd5);
            slot(1, 7'd31, s == 0, 6'd6);
            case (s)
                0: sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                1: sb.push_back(mk(1, 4'b0011, 4'b0011, 5, 6, 0, 0));
                2: begin slot(2, 7'd32, 1'b1, 6'd9); rst_n_i = 1'b0; sb.push_back(mk(0, 0, 4'hf, 0, 0, 0, 0)); end
                default: begin slot(2, 7'd32, 1'b0, 6'd0); sb.push_back(mk(1, 0, 0, 0, 0, 0, 0)); end
            endcase
            tick();
            e = sb.pop_front();
            total++;
            if (obs_v() !== {e.dv, e.v}) begin bad++; $display("FAIL midrst[%0d] vld got %b want %b", s, obs_v(), {e.dv, e.v}); end
            total++;
            if ((obs_t() & e.tm) !== (e.t & e.tm)) begin bad++; $display("FAIL midrst[%0d] tag got %h want %h", s, obs_t() & e.tm, e.t & e.tm); end
        end
    endtask

    initial begin
        idle();
        rst_n_i = 1'b0;
        tick();
        test_reset();
        test_intra_bundle();
        test_issue_bypass();
        test_write_over_issue();
        test_flush();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
